vga_timing_ctrl: RTL

Pixel-timing sequencer for the VGA output path. Generates the pixel clock-enable and the PIX/LINE scan coordinates that drive the image source. Produces HSYNC/VSYNC aligned to the image source's registered RGB output, and blanks that RGB outside the visible area. Sits between the board clock and the VGA connector; the image source hangs off its CE/PIX/LINE outputs and feeds RGB back through it.

---
 rtl/vga_timing_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: pixel-timing sequencer for the VGA output path.
// Divides CLK down to a pixel enable (CE), scans PIX/LINE over the full
// H_TOTAL x V_TOTAL raster, and re-times sync/blanking so that HSYNC, VSYNC,
// ACTIVE and the blanked RGB line up with the image source's registered RGB.
//
// Ports:
//   CLK          system clock
//   RST          synchronous active-high reset (priority over EN)
//   EN           scan enable; low holds the block idle at (0,0)
//   CE           pixel enable to the image source
//   PIX, LINE    current scan coordinates (10 bits each)
//   R_IN/G_IN/B_IN  registered RGB from the image source
//   R/G/B        blanked RGB to the DAC
//   HSYNC/VSYNC  sync outputs, active level SYNC_POL
//   ACTIVE       high when R/G/B carry a visible pixel
//   FRAME_START  one-CLK pulse when the scan wraps to (0,0)
module vga_timing_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CE_DIV    = 2,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    output logic       CE,
    output logic [9:0] PIX,
    output logic [9:0] LINE,
    input  logic [2:0] R_IN,
    input  logic [2:0] G_IN,
    input  logic [1:0] B_IN,
    output logic [2:0] R,
    output logic [2:0] G,
    output logic [1:0] B,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       ACTIVE,
    output logic       FRAME_START
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam int unsigned DIV_W        = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             pix_last;
    logic             line_last;
    logic             hs_c;
    logic             vs_c;
    logic             act_c;
    logic             s1_hs;
    logic             s1_vs;
    logic             s1_act;

    // Wrap detection and timing decode of the current scan position
    always_comb begin
        div_last  = (div_cnt == DIV_W'(CE_DIV - 1));
        pix_last  = (PIX == 10'(H_TOTAL - 1));
        line_last = (LINE == 10'(V_TOTAL - 1));
        hs_c      = (PIX >= 10'(H_SYNC_START)) && (PIX < 10'(H_SYNC_END));
        vs_c      = (LINE >= 10'(V_SYNC_START)) && (LINE < 10'(V_SYNC_END));
        act_c     = (PIX < 10'(H_VISIBLE)) && (LINE < 10'(V_VISIBLE));
    end

    // Divider, scan counters and two-stage alignment pipeline
    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            div_cnt     <= '0;
            CE          <= 1'b0;
            PIX         <= '0;
            LINE        <= '0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
            s1_act      <= 1'b0;
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
            ACTIVE      <= 1'b0;
            R           <= '0;
            G           <= '0;
            B           <= '0;
            FRAME_START <= 1'b0;
        end else begin
            div_cnt     <= div_last ? '0 : div_cnt + DIV_W'(1);
            CE          <= div_last;
            FRAME_START <= 1'b0;
            if (CE) begin
                if (pix_last) begin
                    PIX <= '0;
                    if (line_last) begin
                        LINE        <= '0;
                        FRAME_START <= 1'b1;
                    end else begin
                        LINE <= LINE + 10'd1;
                    end
                end else begin
                    PIX <= PIX + 10'd1;
                end
                // Stage 1 runs alongside the image source's RGB register
                s1_hs  <= hs_c;
                s1_vs  <= vs_c;
                s1_act <= act_c;
                // Stage 2: sync polarity applied, RGB blanked outside visible area
                HSYNC  <= s1_hs ^ ~SYNC_POL;
                VSYNC  <= s1_vs ^ ~SYNC_POL;
                ACTIVE <= s1_act;
                R      <= s1_act ? R_IN : 3'd0;
                G      <= s1_act ? G_IN : 3'd0;
                B      <= s1_act ? B_IN : 2'd0;
            end
        end
    end

endmodule
